// File: rtl/song_pkg.sv
// Shared definitions for the song reader: FSM encoding, ROM word layout and
// the default song geometry.
package song_pkg;

    localparam int unsigned NOTES_PER_SONG_DEF = 32;
    localparam int unsigned SONG_BITS_DEF      = 2;

    localparam int unsigned IDX_W    = 5;
    localparam int unsigned NOTE_W   = 6;
    localparam int unsigned DUR_W    = 6;
    localparam int unsigned WORD_W   = NOTE_W + DUR_W;
    localparam int unsigned ADDR_W   = 7;

    // ROM word layout: {note, duration}
    localparam int unsigned NOTE_MSB = 11;
    localparam int unsigned NOTE_LSB = 6;
    localparam int unsigned DUR_MSB  = 5;
    localparam int unsigned DUR_LSB  = 0;

    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        LOAD      = 3'd3,
        WAIT_NOTE = 3'd4
    } state_t;

endpackage

// File: rtl/dffr.sv
// Codebase flop: asynchronous active-high reset to zero, no enable.
module dffr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q <= '0;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/dffre.sv
// Codebase flop: asynchronous active-high reset to zero, load enable.
module dffre #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/song_rom.sv
// Song ROM, 4 songs x 32 entries of {note, duration}, synchronous read with
// one cycle of latency. A duration of zero marks the end of a song.
module song_rom
    import song_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] dout
);

    logic [NOTE_W-1:0] w_idx;
    logic [NOTE_W-1:0] w_note;
    logic [DUR_W-1:0]  w_dur;
    logic [WORD_W-1:0] r_dout;

    assign w_idx = {1'b0, addr[IDX_W-1:0]};

    // Song 0: 32 full entries; song 1: two notes then end marker;
    // song 2: 32 full entries; song 3: empty (end marker at entry 0).
    always_comb begin
        w_note = '0;
        w_dur  = '0;
        case (addr[ADDR_W-1:IDX_W])
            2'd0: begin
                w_note = w_idx + 6'd1;
                w_dur  = w_idx + 6'd1;
            end
            2'd1: begin
                case (addr[IDX_W-1:0])
                    5'd0: begin
                        w_note = 6'd10;
                        w_dur  = 6'd12;
                    end
                    5'd1: begin
                        w_note = 6'd20;
                        w_dur  = 6'd24;
                    end
                    5'd2: begin
                        w_note = 6'd63;
                        w_dur  = 6'd0;
                    end
                    default: begin
                        w_note = '0;
                        w_dur  = '0;
                    end
                endcase
            end
            2'd2: begin
                w_note = w_idx + 6'd20;
                w_dur  = 6'd2;
            end
            default: begin
                w_note = 6'd5;
                w_dur  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        r_dout <= {w_note, w_dur};
    end

    assign dout = r_dout;

endmodule

// File: rtl/song_reader.sv
// Song reader: walks a song in ROM entry by entry and hands each
// {note, duration} to the note player, pulsing song_done at the end.
module song_reader
    import song_pkg::*;
#(
    parameter int unsigned NOTES_PER_SONG = NOTES_PER_SONG_DEF,
    parameter int unsigned SONG_BITS      = SONG_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play,
    input  logic [SONG_BITS-1:0] song,
    input  logic                 new_song,
    input  logic                 done_with_note,
    output logic [NOTE_W-1:0]    note_to_load,
    output logic [DUR_W-1:0]     duration_to_load,
    output logic                 load_new_note,
    output logic                 song_done,
    output logic [IDX_W-1:0]     note_index
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

    logic [STATE_W-1:0]   r_state_q;
    logic [SONG_BITS-1:0] r_song;
    logic [IDX_W-1:0]     r_idx;
    logic [NOTE_W-1:0]    r_note;
    logic [DUR_W-1:0]     r_dur;
    logic                 r_done;

    state_t               w_state;
    state_t               w_state_nxt;
    logic [STATE_W-1:0]   w_state_d;
    logic                 w_song_en;
    logic                 w_idx_en;
    logic [IDX_W-1:0]     w_idx_d;
    logic                 w_out_en;
    logic                 w_done_d;
    logic [ADDR_W-1:0]    w_addr;
    logic [WORD_W-1:0]    w_rom;
    logic [NOTE_W-1:0]    w_rom_note;
    logic [DUR_W-1:0]     w_rom_dur;

    assign w_state    = state_t'(r_state_q);
    assign w_state_d  = w_state_nxt;
    assign w_addr     = {r_song, r_idx};
    assign w_rom_note = w_rom[NOTE_MSB:NOTE_LSB];
    assign w_rom_dur  = w_rom[DUR_MSB:DUR_LSB];

    song_rom u_rom (
        .clk  (clk),
        .addr (w_addr),
        .dout (w_rom)
    );

    // new_song overrides everything, including play and done_with_note
    always_comb begin
        w_state_nxt = w_state;
        w_song_en   = 1'b0;
        w_idx_en    = 1'b0;
        w_idx_d     = r_idx;
        w_out_en    = 1'b0;
        w_done_d    = 1'b0;
        if (new_song) begin
            w_state_nxt = FETCH;
            w_song_en   = 1'b1;
            w_idx_en    = 1'b1;
            w_idx_d     = '0;
        end else if (play) begin
            case (w_state)
                IDLE: w_state_nxt = IDLE;
                FETCH: w_state_nxt = DECODE;
                DECODE: begin
                    if (w_rom_dur == '0) begin
                        w_state_nxt = IDLE;
                        w_done_d    = 1'b1;
                    end else begin
                        w_state_nxt = LOAD;
                        w_out_en    = 1'b1;
                    end
                end
                LOAD: w_state_nxt = WAIT_NOTE;
                WAIT_NOTE: begin
                    if (done_with_note) begin
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = IDLE;
                            w_done_d    = 1'b1;
                        end else begin
                            w_state_nxt = FETCH;
                            w_idx_en    = 1'b1;
                            w_idx_d     = r_idx + IDX_W'(1);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    dffr #(.WIDTH(STATE_W)) u_state (
        .i_clk (clk), .i_rst (reset), .i_d (w_state_d), .o_q (r_state_q)
    );

    dffre #(.WIDTH(SONG_BITS)) u_song (
        .i_clk (clk), .i_rst (reset), .i_en (w_song_en), .i_d (song), .o_q (r_song)
    );

    dffre #(.WIDTH(IDX_W)) u_idx (
        .i_clk (clk), .i_rst (reset), .i_en (w_idx_en), .i_d (w_idx_d), .o_q (r_idx)
    );

    dffre #(.WIDTH(NOTE_W)) u_note (
        .i_clk (clk), .i_rst (reset), .i_en (w_out_en), .i_d (w_rom_note), .o_q (r_note)
    );

    dffre #(.WIDTH(DUR_W)) u_dur (
        .i_clk (clk), .i_rst (reset), .i_en (w_out_en), .i_d (w_rom_dur), .o_q (r_dur)
    );

    dffr #(.WIDTH(1)) u_done (
        .i_clk (clk), .i_rst (reset), .i_d (w_done_d), .o_q (r_done)
    );

    // Decoded from the registered state, so reset clears it immediately
    assign load_new_note    = (w_state == LOAD) && play;
    assign note_to_load     = r_note;
    assign duration_to_load = r_dur;
    assign song_done        = r_done;
    assign note_index       = r_idx;

endmodule

// File: tb/tb_song_reader.sv
// Directed self-checking bench for song_reader with hand-computed ROM
// expectations.
module tb_song_reader;

    logic       clk;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       new_song;
    logic       done_with_note;
    logic [5:0] note_to_load;
    logic [5:0] duration_to_load;
    logic       load_new_note;
    logic       song_done;
    logic [4:0] note_index;

    int unsigned n_checks;
    int unsigned n_fails;

    song_reader #(
        .NOTES_PER_SONG (32),
        .SONG_BITS      (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .new_song         (new_song),
        .done_with_note   (done_with_note),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done),
        .note_index       (note_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned seen_load;
        int unsigned seen_done;

        n_checks       = 0;
        n_fails        = 0;
        reset          = 1'b1;
        play           = 1'b0;
        song           = 2'd0;
        new_song       = 1'b0;
        done_with_note = 1'b0;

        step();
        step();
        check_eq("rst_note", note_to_load, 0);
        check_eq("rst_dur", duration_to_load, 0);
        check_eq("rst_load", load_new_note, 0);
        check_eq("rst_done", song_done, 0);
        check_eq("rst_idx", note_index, 0);
        reset = 1'b0;

        // Song 1, entry 0: load three cycles after new_song
        song = 2'd1; new_song = 1'b1; play = 1'b1;
        step(); new_song = 1'b0;
        check_eq("s1_fetch_load", load_new_note, 0);
        step();
        check_eq("s1_decode_load", load_new_note, 0);
        step();
        check_eq("s1e0_load", load_new_note, 1);
        check_eq("s1e0_note", note_to_load, 10);
        check_eq("s1e0_dur", duration_to_load, 12);
        check_eq("s1e0_idx", note_index, 0);
        step();
        check_eq("s1e0_wait_load", load_new_note, 0);
        step();
        check_eq("s1e0_hold_idx", note_index, 0);

        // Advance to entry 1
        done_with_note = 1'b1;
        step(); done_with_note = 1'b0;
        check_eq("s1e1_idx", note_index, 1);
        check_eq("s1e1_fetch_load", load_new_note, 0);
        step();
        step();
        check_eq("s1e1_load", load_new_note, 1);
        check_eq("s1e1_note", note_to_load, 20);
        check_eq("s1e1_dur", duration_to_load, 24);
        step();

        // Entry 2 is the end marker
        done_with_note = 1'b1;
        step(); done_with_note = 1'b0;
        check_eq("s1e2_idx", note_index, 2);
        step();
        check_eq("s1e2_decode_done", song_done, 0);
        step();
        check_eq("s1_end_done", song_done, 1);
        check_eq("s1_end_load", load_new_note, 0);
        check_eq("s1_end_note", note_to_load, 20);
        check_eq("s1_end_dur", duration_to_load, 24);
        check_eq("s1_end_idx", note_index, 2);
        step();
        check_eq("s1_done_pulse", song_done, 0);
        done_with_note = 1'b1;
        step(); done_with_note = 1'b0;
        check_eq("idle_dwn_idx", note_index, 2);
        check_eq("idle_dwn_load", load_new_note, 0);

        // Stall in DECODE with play low for 10 cycles
        song = 2'd1; new_song = 1'b1;
        step(); new_song = 1'b0;
        step();
        play = 1'b0;
        seen_load = 0;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (load_new_note) seen_load++;
            if (song_done) seen_done++;
        end
        check_eq("stall_load", seen_load, 0);
        check_eq("stall_done", seen_done, 0);
        check_eq("stall_note", note_to_load, 20);
        play = 1'b1;
        #1;
        check_eq("resume_decode_load", load_new_note, 0);
        step();
        check_eq("resume_load", load_new_note, 1);
        check_eq("resume_note", note_to_load, 10);
        check_eq("resume_dur", duration_to_load, 12);
        step();

        // done_with_note ignored while play is low
        play = 1'b0; done_with_note = 1'b1;
        step(); step(); step();
        check_eq("paused_wait_idx", note_index, 0);
        check_eq("paused_wait_load", load_new_note, 0);
        play = 1'b1; done_with_note = 1'b0;

        // new_song beats simultaneous done_with_note
        song = 2'd2; new_song = 1'b1; done_with_note = 1'b1;
        step(); new_song = 1'b0; done_with_note = 1'b0;
        check_eq("s2_prio_idx", note_index, 0);
        step();
        step();
        check_eq("s2e0_load", load_new_note, 1);
        check_eq("s2e0_note", note_to_load, 20);
        check_eq("s2e0_dur", duration_to_load, 2);

        // Asynchronous reset while in LOAD
        #2 reset = 1'b1;
        #1;
        check_eq("arst_load", load_new_note, 0);
        check_eq("arst_note", note_to_load, 0);
        check_eq("arst_dur", duration_to_load, 0);
        check_eq("arst_idx", note_index, 0);
        check_eq("arst_done", song_done, 0);
        step(); reset = 1'b0;
        seen_load = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (load_new_note) seen_load++;
        end
        check_eq("post_rst_idle_load", seen_load, 0);

        // Song 0: all 32 entries, then end at the last index
        song = 2'd0; new_song = 1'b1;
        step(); new_song = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            step();
            check_eq("s0_load", load_new_note, 1);
            check_eq("s0_note", note_to_load, i + 1);
            check_eq("s0_dur", duration_to_load, i + 1);
            check_eq("s0_idx", note_index, i);
            step();
            check_eq("s0_wait_done", song_done, 0);
            done_with_note = 1'b1;
            step(); done_with_note = 1'b0;
        end
        check_eq("s0_end_done", song_done, 1);
        check_eq("s0_end_idx", note_index, 31);
        check_eq("s0_end_load", load_new_note, 0);
        seen_load = 0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (load_new_note) seen_load++;
            if (song_done) seen_done++;
        end
        check_eq("s0_after_load", seen_load, 0);
        check_eq("s0_after_done", seen_done, 0);
        check_eq("s0_after_idx", note_index, 31);

        // Song 3 is empty: ends at entry 0 without loading
        song = 2'd3; new_song = 1'b1;
        step(); new_song = 1'b0;
        step();
        check_eq("s3_decode_load", load_new_note, 0);
        step();
        check_eq("s3_done", song_done, 1);
        check_eq("s3_load", load_new_note, 0);
        check_eq("s3_note", note_to_load, 32);
        check_eq("s3_idx", note_index, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
